// File: rtl/resp_checker_pkg.sv
// resp_checker_pkg: shared FSM state type and golden response model
package resp_checker_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic logic [1:0] golden(input logic a, input logic b, input logic c);
    return {(a & b) | ~c, ~c};
  endfunction
endpackage

// File: rtl/resp_golden.sv
// resp_golden: combinational expected-output model for one response beat
module resp_golden
  import resp_checker_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d_exp,
  output logic e_exp
);
  assign {d_exp, e_exp} = golden(a, b, c);
endmodule

// File: rtl/resp_checker.sv
// resp_checker: scores a run of response beats against the golden model
module resp_checker
  import resp_checker_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             order_err,
  output logic             done,
  output logic             all_pass
);
  state_e           state;
  logic [CNT_W-1:0] idx;
  logic             d_exp, e_exp, acc, hit, last;
  resp_golden u_golden (.a(a), .b(b), .c(c), .d_exp(d_exp), .e_exp(e_exp));
  assign in_ready = state == RUN;
  assign acc      = in_valid & in_ready;
  assign hit      = (d == d_exp) && (e == e_exp);
  assign last     = idx == CNT_W'(NUM_VEC - 1);
  assign done     = state == DONE;
  assign all_pass = done && fail_cnt == '0 && !order_err;
  // run control and scoring; start is only honoured outside RUN, so a start
  // coinciding with the final beat cannot restart the run
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '1;
      order_err      <= 1'b0;
    end else if (state != RUN && start) begin
      state          <= RUN;
      idx            <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '1;
      order_err      <= 1'b0;
    end else if (acc) begin
      pass_cnt <= (hit && !(&pass_cnt)) ? pass_cnt + 1'b1 : pass_cnt;
      fail_cnt <= (!hit && !(&fail_cnt)) ? fail_cnt + 1'b1 : fail_cnt;
      idx      <= (&idx) ? idx : idx + 1'b1;
      if (!hit && fail_cnt == '0) first_fail_idx <= idx;
      if ({a, b, c} != idx[2:0]) order_err <= 1'b1;
      if (last) state <= DONE;
    end
  end
endmodule

// File: tb/tb_resp_checker.sv
// tb_resp_checker: directed scenario tests for resp_checker
module tb_resp_checker;
  logic clk, rst, start, in_valid, a, b, c, d, e;
  logic rdy, oe, dn, ap, rdy4, oe4, dn4, ap4, rdys, oes, dns, aps;
  logic [7:0] p, f, ffi, p4, f4, ffi4;
  logic [2:0] ps, fs, ffis;
  logic [7:0] d_tab = 8'hD5;
  logic [7:0] e_tab = 8'h55;
  int cmp = 0;
  int errs = 0;

  resp_checker dut (.clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy),
    .a(a), .b(b), .c(c), .d(d), .e(e), .pass_cnt(p), .fail_cnt(f), .first_fail_idx(ffi),
    .order_err(oe), .done(dn), .all_pass(ap));
  resp_checker #(.NUM_VEC(4)) dut4 (.clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(rdy4), .a(a), .b(b), .c(c), .d(d), .e(e), .pass_cnt(p4), .fail_cnt(f4),
    .first_fail_idx(ffi4), .order_err(oe4), .done(dn4), .all_pass(ap4));
  resp_checker #(.NUM_VEC(8), .CNT_W(3)) dut_s (.clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(rdys), .a(a), .b(b), .c(c), .d(d), .e(e), .pass_cnt(ps),
    .fail_cnt(fs), .first_fail_idx(ffis), .order_err(oes), .done(dns), .all_pass(aps));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input int v, input bit flip);
    {a, b, c} = v[2:0];
    d = d_tab[v] ^ flip;
    e = e_tab[v];
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp++; if (rdy !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", rdy); end
    cmp++; if (p !== 8'd0) begin errs++; $display("FAIL rst_pass: got %0d want 0", p); end
    cmp++; if (f !== 8'd0) begin errs++; $display("FAIL rst_fail: got %0d want 0", f); end
    cmp++; if (ffi !== 8'hFF) begin errs++; $display("FAIL rst_ffi: got %0h want ff", ffi); end
    cmp++; if (oe !== 1'b0) begin errs++; $display("FAIL rst_order: got %b want 0", oe); end
    cmp++; if (dn !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", dn); end
    cmp++; if (ap !== 1'b0) begin errs++; $display("FAIL rst_allpass: got %b want 0", ap); end
    beat(0, 1'b1);
    cmp++; if (p !== 8'd0 || f !== 8'd0) begin errs++; $display("FAIL idle_drop: got p=%0d f=%0d want 0 0", p, f); end
  endtask

  task automatic test_all_pass();
    pulse_start();
    cmp++; if (rdy !== 1'b1) begin errs++; $display("FAIL run_ready: got %b want 1", rdy); end
    beat(0, 1'b0);
    cmp++; if (p !== 8'd1) begin errs++; $display("FAIL latency_pass: got %0d want 1", p); end
    for (int i = 1; i < 7; i++) beat(i, 1'b0);
    cmp++; if (dn !== 1'b0) begin errs++; $display("FAIL early_done: got %b want 0", dn); end
    beat(7, 1'b0);
    cmp++; if (dn !== 1'b1) begin errs++; $display("FAIL ap_done: got %b want 1", dn); end
    cmp++; if (p !== 8'd8) begin errs++; $display("FAIL ap_pass: got %0d want 8", p); end
    cmp++; if (f !== 8'd0) begin errs++; $display("FAIL ap_fail: got %0d want 0", f); end
    cmp++; if (ap !== 1'b1) begin errs++; $display("FAIL ap_allpass: got %b want 1", ap); end
    cmp++; if (ffi !== 8'hFF) begin errs++; $display("FAIL ap_ffi: got %0h want ff", ffi); end
    cmp++; if (rdy !== 1'b0) begin errs++; $display("FAIL done_ready: got %b want 0", rdy); end
    cmp++; if (ps !== 3'd7 || dns !== 1'b1) begin errs++; $display("FAIL sat_pass: got p=%0d done=%b want 7 1", ps, dns); end
    beat(1, 1'b1);
    cmp++; if (p !== 8'd8 || f !== 8'd0) begin errs++; $display("FAIL done_drop: got p=%0d f=%0d want 8 0", p, f); end
  endtask

  task automatic test_mismatch();
    pulse_start();
    cmp++; if (p !== 8'd0 || dn !== 1'b0) begin errs++; $display("FAIL restart_clear: got p=%0d done=%b want 0 0", p, dn); end
    for (int i = 0; i < 3; i++) beat(i, i == 2);
    cmp++; if (ffi !== 8'd2 || f !== 8'd1) begin errs++; $display("FAIL mm_first: got ffi=%0d f=%0d want 2 1", ffi, f); end
    for (int i = 3; i < 8; i++) beat(i, i == 5);
    cmp++; if (p !== 8'd6) begin errs++; $display("FAIL mm_pass: got %0d want 6", p); end
    cmp++; if (f !== 8'd2) begin errs++; $display("FAIL mm_fail: got %0d want 2", f); end
    cmp++; if (ffi !== 8'd2) begin errs++; $display("FAIL mm_ffi: got %0d want 2", ffi); end
    cmp++; if (ap !== 1'b0 || dn !== 1'b1) begin errs++; $display("FAIL mm_allpass: got ap=%b done=%b want 0 1", ap, dn); end
  endtask

  task automatic test_order();
    int seq[8] = '{0, 1, 2, 4, 3, 5, 6, 7};
    pulse_start();
    for (int i = 0; i < 8; i++) beat(seq[i], 1'b0);
    cmp++; if (oe !== 1'b1) begin errs++; $display("FAIL ord_err: got %b want 1", oe); end
    cmp++; if (f !== 8'd0 || p !== 8'd8) begin errs++; $display("FAIL ord_cnt: got p=%0d f=%0d want 8 0", p, f); end
    cmp++; if (ap !== 1'b0 || dn !== 1'b1) begin errs++; $display("FAIL ord_allpass: got ap=%b done=%b want 0 1", ap, dn); end
  endtask

  task automatic test_stall();
    pulse_start();
    beat(0, 1'b0);
    beat(1, 1'b0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    cmp++; if (p !== 8'd2 || rdy !== 1'b1) begin errs++; $display("FAIL stall_hold: got p=%0d rdy=%b want 2 1", p, rdy); end
    for (int i = 2; i < 7; i++) beat(i, 1'b0);
    start = 1'b1;
    beat(7, 1'b0);
    start = 1'b0;
    cmp++; if (dn !== 1'b1 || p !== 8'd8 || f !== 8'd0) begin errs++; $display("FAIL stall_res: got done=%b p=%0d f=%0d want 1 8 0", dn, p, f); end
    cmp++; if (ap !== 1'b1 || ffi !== 8'hFF) begin errs++; $display("FAIL stall_ap: got ap=%b ffi=%0h want 1 ff", ap, ffi); end
    step();
    cmp++; if (dn !== 1'b1 || p !== 8'd8) begin errs++; $display("FAIL last_start: got done=%b p=%0d want 1 8", dn, p); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 5; i++) beat(i, i == 1);
    rst = 1'b1; start = 1'b1; {a, b, c} = 3'd5; d = 1'b0; e = 1'b0; in_valid = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    cmp++; if (p !== 8'd0 || f !== 8'd0 || ffi !== 8'hFF) begin errs++; $display("FAIL mid_cnt: got p=%0d f=%0d ffi=%0h want 0 0 ff", p, f, ffi); end
    cmp++; if (rdy !== 1'b0 || dn !== 1'b0 || oe !== 1'b0 || ap !== 1'b0) begin errs++; $display("FAIL mid_flags: got rdy=%b dn=%b oe=%b ap=%b want 0 0 0 0", rdy, dn, oe, ap); end
    pulse_start();
    for (int i = 0; i < 8; i++) beat(i, 1'b0);
    cmp++; if (ap !== 1'b1 || p !== 8'd8) begin errs++; $display("FAIL mid_rerun: got ap=%b p=%0d want 1 8", ap, p); end
  endtask

  task automatic test_num4();
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) beat(i, 1'b0);
    cmp++; if (dn4 !== 1'b1 || p4 !== 8'd4 || ap4 !== 1'b1) begin errs++; $display("FAIL n4_run1: got dn=%b p=%0d ap=%b want 1 4 1", dn4, p4, ap4); end
    pulse_start();
    cmp++; if (dn4 !== 1'b0 || p4 !== 8'd0 || rdy4 !== 1'b1) begin errs++; $display("FAIL n4_clear: got dn=%b p=%0d rdy=%b want 0 0 1", dn4, p4, rdy4); end
    for (int i = 0; i < 4; i++) beat(i, i == 1);
    cmp++; if (dn4 !== 1'b1 || p4 !== 8'd3 || f4 !== 8'd1) begin errs++; $display("FAIL n4_run2: got dn=%b p=%0d f=%0d want 1 3 1", dn4, p4, f4); end
    cmp++; if (ffi4 !== 8'd1 || ap4 !== 1'b0 || oe4 !== 1'b0) begin errs++; $display("FAIL n4_ffi: got ffi=%0d ap=%b oe=%b want 1 0 0", ffi4, ap4, oe4); end
  endtask

  initial begin
    {a, b, c, d, e} = '0;
    test_reset();
    test_all_pass();
    test_mismatch();
    test_order();
    test_stall();
    test_reset_mid();
    test_num4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
